// File: rtl/sha3_squeeze_if.sv
// sha3_squeeze_if: digest lane stream, one 64-bit lane per valid/ready beat.
// master drives lanes out, slave is the digest consumer.
interface sha3_squeeze_if;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );
endinterface

// File: rtl/sha3_squeeze.sv
// sha3_squeeze: captures the final SHA3 state, streams DIGEST_LANES lanes.
// SHA3_SQUEEZE_PINGPONG_EN selects two digest buffers instead of one.
module sha3_squeeze #(
  parameter int DIGEST_LANES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [63:0]    isa [5],
  input  logic [63:0]    isb [5],
  input  logic [63:0]    isc [5],
  input  logic [63:0]    isd [5],
  input  logic [63:0]    ise [5],
  input  logic           sample,
  sha3_squeeze_if.master dout_if,
  output logic           busy,
  output logic           overflow
);

  localparam int L  = DIGEST_LANES;
  localparam int IW = $clog2(L + 1);

`ifdef SHA3_SQUEEZE_PINGPONG_EN
  localparam logic [1:0] NS = 2'd2;
`else
  localparam logic [1:0] NS = 2'd1;
`endif

  logic [63:0]   lanes [25];
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          valid, fire, fin, acc;
  logic [63:0]   rd;
  logic          unused_lanes;

  // Linear lane index is 5*y + x.
  always_comb begin
    for (int x = 0; x < 5; x++) begin
      lanes[x]      = isa[x];
      lanes[5 + x]  = isb[x];
      lanes[10 + x] = isc[x];
      lanes[15 + x] = isd[x];
      lanes[20 + x] = ise[x];
    end
  end

  always_comb begin
    unused_lanes = 1'b0;
    for (int k = L; k < 25; k++) begin
      unused_lanes = unused_lanes ^ (^lanes[k]);
    end
  end

  always_comb begin
    valid = occ_q != 2'd0;
    fire  = valid && dout_if.dout_ready;
    fin   = fire && (idx_q == IW'(L - 1));
    // A final transfer frees its slot in time for a same-cycle capture.
    acc   = sample && ((occ_q != NS) || fin);
    occ_d = occ_q + {1'b0, acc} - {1'b0, fin};
    ovf_d = ovf_q | (sample & ~acc);
    idx_d = idx_q;
    if (fin) begin
      idx_d = '0;
    end else if (fire) begin
      idx_d = idx_q + IW'(1);
    end
  end

`ifdef SHA3_SQUEEZE_PINGPONG_EN
  logic [63:0] mem_q [2][L];
  logic        wp_q, wp_d;
  logic        rp_q, rp_d;

  always_comb begin
    wp_d = wp_q ^ acc;
    rp_d = rp_q ^ fin;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int j = 0; j < L; j++) begin
        mem_q[wp_q][j] <= lanes[j];
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int j = 0; j < L; j++) begin
      if (idx_q == IW'(j)) begin
        rd = mem_q[rp_q][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= 1'b0;
      rp_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
`else
  logic [63:0] mem_q [L];

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int j = 0; j < L; j++) begin
        mem_q[j] <= lanes[j];
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int j = 0; j < L; j++) begin
      if (idx_q == IW'(j)) begin
        rd = mem_q[j];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  assign dout_if.dout_valid = valid;
  assign dout_if.dout       = valid ? rd : 64'h0;
  assign dout_if.dout_last  = valid && (idx_q == IW'(L - 1));
  assign busy               = valid;
  assign overflow           = ovf_q;

endmodule

// File: doc/sha3_squeeze.md
# sha3_squeeze

Output stage of the SHA3 permutation pipeline. It captures the final 5×5 state from the last round step (iota) when `sample` is strobed and keeps the first `DIGEST_LANES` lanes. It then returns them one 64-bit lane per handshake on a valid/ready stream towards the digest consumer. The round pipeline has no backpressure, so the block buffers whole digests and flags any state it has to drop.

## Interface
- `DIGEST_LANES`, 4, number of 64-bit lanes emitted per digest; legal range 1..25 (4 = SHA3-256, 8 = SHA3-512)
- `clk` input 1: single clock; all logic on its rising edge
- `rst` input 1: synchronous, active-high reset
- `isa`,`isb`,`isc`,`isd`,`ise` input 64×[5] each: state rows y=0..4; `isa[x]` is lane x of row 0; linear lane index = 5·y + x
- `sample` input 1: one-cycle strobe; state inputs are valid this cycle (driven by iota `good`)
- `dout` output 64: current digest lane
- `dout_valid` output 1: `dout` holds a lane
- `dout_ready` input 1: consumer accepts `dout` this cycle
- `dout_last` output 1: current lane is lane `DIGEST_LANES-1` of its digest
- `busy` output 1: at least one digest is buffered
- `overflow` output 1: sticky; a `sample` was dropped since reset

## Operation
- Capture: on `sample`, if a slot is free, the lanes at linear indices 0..`DIGEST_LANES-1` are stored into the write slot; the other lanes are discarded.
- Slots:
  - Two digest buffers in ping-pong, with write pointer, read pointer and occupancy 0..2.
  - One buffer when the macro is off (see Configuration).
- Emission:
  - Lane counter `idx` runs 0..`DIGEST_LANES-1` over the read slot.
  - `dout` = read-slot lane[`idx`] when `dout_valid`, else 64'h0.
  - A transfer occurs when `dout_valid && dout_ready`; it increments `idx`.
  - On the transfer with `idx == DIGEST_LANES-1`: `idx` returns to 0, the read pointer toggles and occupancy decrements.
- `dout_valid` = occupancy != 0.
- `dout_last` = `dout_valid && idx == DIGEST_LANES-1`.
- `busy` = `dout_valid`.
- Drop: `sample` while occupancy is full and no final transfer happens in the same cycle. The state is discarded, `overflow` is set and held until `rst`, and buffered data is untouched.
- Simultaneous final transfer and `sample` at full occupancy: the slot being freed is reused. The new digest is accepted and occupancy is unchanged.
- Simultaneous final transfer and `sample` at occupancy 1:
  - Ping-pong: occupancy stays 1 and the new digest follows immediately.
  - Single buffer: the buffer is overwritten with the new digest and occupancy stays 1.
- `dout_ready` without `dout_valid`: ignored.
- No `DIGEST_LANES`-dependent arithmetic wraps beyond the counter. `idx` is $clog2(`DIGEST_LANES`+1) bits wide and never exceeds `DIGEST_LANES-1`.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `overflow`=0, `idx`=0, pointers=0, occupancy=0.
- `rst` mid-digest: all buffered digests are lost and the outputs return to reset values on the next cycle. Buffer contents need no clearing because `dout` is masked.
- Latency: `sample` in cycle N gives `dout_valid`=1 with lane 0 in cycle N+1, when the block was empty.
- Throughput: one lane per cycle with `dout_ready` held high. A following digest already buffered continues with no bubble; its lane 0 appears the cycle after the previous lane `DIGEST_LANES-1`.
- `dout`, `dout_valid` and `dout_last` stay stable while `dout_valid && !dout_ready`.
- `overflow` rises the cycle after the dropped `sample`.
- `DIGEST_LANES`=1: every transfer is a final transfer and `dout_last` equals `dout_valid`.

## Configuration
- `SHA3_SQUEEZE_PINGPONG_EN` defined: two digest buffers; at most two digests are held.
- `SHA3_SQUEEZE_PINGPONG_EN` undefined: one buffer.
  - A `sample` is accepted only while empty, or in the same cycle as the final transfer.
  - Any other `sample` while busy sets `overflow`.
  - Pointers are removed.
- Ports and latency are identical in both builds.

## Test plan
- Reset/idle: assert `rst` 2 cycles, then idle 10 cycles -> all outputs 0; `dout_ready`=1 causes no transfer.
- Single digest, `DIGEST_LANES`=4: `sample` with `isa`={1,2,3,4,5} -> next cycle `dout_valid`=1; with `dout_ready`=1, `dout` emits 1,2,3,4 on consecutive cycles, `dout_last` only on 4, then `dout_valid`=0.
- Lane mapping, `DIGEST_LANES`=8: `isa`={0..4}, `isb`={5..9} as values -> emitted 0,1,2,3,4,5,6,7.
- Backpressure: `dout_ready` toggling 1,0,0,1,… -> each lane held stable while stalled; sequence and `dout_last` are unchanged.
- Ping-pong: two `sample`s 1 cycle apart, `dout_ready`=0 -> both kept, `overflow`=0. A third `sample` -> `overflow`=1 the next cycle. Release ready -> 8 lanes of digests 1 then 2, no bubble.
- Edge cases:
  - `sample` coincident with the final transfer at full occupancy -> accepted, `overflow` stays 0.
  - `rst` after lane 1 of a digest -> `dout_valid`=0 next cycle; a fresh `sample` restarts at lane 0.
